// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter sharing one memory request port between N_REQ requesters.
// An in-order ID FIFO records each accepted request's owner so responses route back to it.
module mem_request_arbiter #(
  parameter type REQ_T = logic [15:0],
  parameter type RSP_T = logic [7:0],
  parameter int  N_REQ = 2,
  parameter int  DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          nreset,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*$bits(REQ_T)-1:0] req_data,
  output logic                          down_valid,
  input  logic                          down_ready,
  output logic [$bits(REQ_T)-1:0]       down_data,
  input  logic                          rsp_valid,
  output logic                          rsp_ready,
  input  logic [$bits(RSP_T)-1:0]       rsp_data,
  output logic [N_REQ-1:0]              out_rsp_valid,
  input  logic [N_REQ-1:0]              out_rsp_ready,
  output logic [$bits(RSP_T)-1:0]       out_rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]    outstanding,
  output logic                          orphan_err
);

  localparam int RW  = $bits(REQ_T);
  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic           r_down_valid;
  logic [RW-1:0]  r_down_data;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] r_id_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_orphan;

  logic [RW-1:0]  w_req_arr [N_REQ];
  logic           w_load_en;
  logic           w_hi_found;
  logic           w_lo_found;
  logic [IDW-1:0] w_hi_idx;
  logic [IDW-1:0] w_lo_idx;
  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic [RW-1:0]  w_grant_data;
  logic           w_accept;
  logic           w_empty;
  logic [IDW-1:0] w_head;
  logic           w_head_ready;
  logic           w_push;
  logic           w_pop;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_arr[gi] = req_data[gi*RW +: RW];
    end
  endgenerate

  assign w_load_en = (!r_down_valid || down_ready) && (r_count != FULL_CNT);

  // Requesters above r_last win over the wrapped-around ones; lowest index wins within each group.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > r_last) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDW'(i);
        end
      end
    end
    w_found = w_hi_found || w_lo_found;
    w_grant = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == IDW'(i)) w_grant_data = w_req_arr[i];
    end
  end

  assign w_accept = w_load_en && w_found;
  assign w_empty  = (r_count == '0);
  assign w_head   = r_id_mem[r_rd_ptr];

  always_comb begin
    w_head_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_head == IDW'(i)) w_head_ready = out_rsp_ready[i];
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ports
      assign req_ready[gi]     = w_accept && req_valid[gi] && (w_grant == IDW'(gi));
      assign out_rsp_valid[gi] = rsp_valid && !w_empty && (w_head == IDW'(gi));
    end
  endgenerate

  assign rsp_ready = !w_empty && w_head_ready;
  assign w_push    = w_accept;
  assign w_pop     = rsp_valid && rsp_ready;

  // A completed downstream handshake with no new accept (e.g. FIFO full) must still drain the register.
  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      r_down_valid <= 1'b0;
      r_down_data  <= '0;
      r_last       <= IDW'(N_REQ - 1);
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_orphan     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_down_valid <= 1'b1;
        r_down_data  <= w_grant_data;
        r_last       <= w_grant;
      end else if (!r_down_valid || down_ready) begin
        r_down_valid <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (rsp_valid && w_empty) r_orphan <= 1'b1;
    end
  end

  always_ff @(negedge clock) begin
    if (w_push) r_id_mem[r_wr_ptr] <= w_grant;
  end

  assign down_valid   = r_down_valid;
  assign down_data    = r_down_data;
  assign out_rsp_data = rsp_data;
  assign outstanding  = r_count;
  assign orphan_err   = r_orphan;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench for mem_request_arbiter: stimulus queues expected downstream payloads and
// routed responses; a monitor pops and compares on every handshake.
module tb_mem_request_arbiter;

  logic        clock = 1'b0;
  logic        nreset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_data;
  logic        down_valid;
  logic        down_ready;
  logic [15:0] down_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  out_rsp_valid;
  logic [1:0]  out_rsp_ready;
  logic [7:0]  out_rsp_data;
  logic [2:0]  outstanding;
  logic        orphan_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_down [$];
  logic [9:0]  exp_rsp  [$];

  mem_request_arbiter #(
    .REQ_T (logic [15:0]),
    .RSP_T (logic [7:0]),
    .N_REQ (2),
    .DEPTH (4)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .down_valid    (down_valid),
    .down_ready    (down_ready),
    .down_data     (down_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .out_rsp_valid (out_rsp_valid),
    .out_rsp_ready (out_rsp_ready),
    .out_rsp_data  (out_rsp_data),
    .outstanding   (outstanding),
    .orphan_err    (orphan_err)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Inputs change 1 unit after the rising edge; everything is sampled at +3, before the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [15:0] ed;
    logic [9:0]  er;
    forever begin
      @(posedge clock);
      #3;
      if (down_valid && down_ready) begin
        if (exp_down.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL down_unexpected: got 0x%0h, expected no transfer", down_data);
        end else begin
          ed = exp_down.pop_front();
          chk("down_xfer", {16'h0, down_data}, {16'h0, ed});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got 0x%0h, expected no transfer", {out_rsp_valid, out_rsp_data});
        end else begin
          er = exp_rsp.pop_front();
          chk("rsp_xfer", {22'h0, out_rsp_valid, out_rsp_data}, {22'h0, er});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset        = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    down_ready    = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    out_rsp_ready = 2'b11;

    // Reset state; request path still evaluates from reset state
    tick(); req_valid = 2'b10; settle();
    chk("rst_down_valid", down_valid, 0);
    chk("rst_down_data", down_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_orphan", orphan_err, 0);
    chk("rst_req_ready", req_ready, 2'b10);
    chk("rst_rsp_ready", rsp_ready, 0);

    // Single requester round trip
    tick(); nreset = 1'b1; req_valid = 2'b01; req_data = 32'h0000_0100; down_ready = 1'b1;
    exp_down.push_back(16'h0100);
    settle();
    chk("single_req_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00; settle();
    chk("single_down_valid", down_valid, 1);
    chk("single_down_data", down_data, 16'h0100);
    chk("single_outstanding", outstanding, 1);
    tick(); rsp_valid = 1'b1; rsp_data = 8'hAB; exp_rsp.push_back({2'b01, 8'hAB}); settle();
    chk("single_rsp_valid", out_rsp_valid, 2'b01);
    chk("single_rsp_data", out_rsp_data, 8'hAB);
    chk("single_rsp_ready", rsp_ready, 1);
    tick(); rsp_valid = 1'b0; settle();
    chk("single_outstanding_done", outstanding, 0);
    chk("single_down_drained", down_valid, 0);

    // Burst to outstanding=3, then reset mid-burst (third payload never leaves)
    for (int c = 0; c < 3; c++) begin
      tick(); req_valid = 2'b01; req_data = 32'h0000_0111; down_ready = 1'b1;
      if (c < 2) exp_down.push_back(16'h0111);
      settle();
      chk("burst_req_ready", req_ready, 2'b01);
    end
    tick(); req_valid = 2'b00; down_ready = 1'b0; settle();
    chk("burst_outstanding", outstanding, 3);
    chk("burst_down_valid", down_valid, 1);
    tick(); nreset = 1'b0; settle();
    chk("midrst_down_valid", down_valid, 0);
    chk("midrst_down_data", down_data, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_orphan", orphan_err, 0);

    // Fairness: both valid, grants alternate from requester 0, responses one cycle behind
    for (int c = 0; c < 6; c++) begin
      tick(); nreset = 1'b1; down_ready = 1'b1; out_rsp_ready = 2'b11;
      req_valid = (c < 4) ? 2'b11 : 2'b00;
      req_data  = 32'h00B1_00A0;
      if (c < 4) exp_down.push_back((c % 2 == 0) ? 16'h00A0 : 16'h00B1);
      rsp_valid = (c >= 2);
      rsp_data  = 8'h50 + 8'(c - 2);
      if (c >= 2) exp_rsp.push_back({((c % 2 == 0) ? 2'b01 : 2'b10), rsp_data});
      settle();
      chk("fair_req_ready", req_ready, (c < 4) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      if (c >= 2) chk("fair_rsp_route", out_rsp_valid, (c % 2 == 0) ? 2'b01 : 2'b10);
    end
    tick(); rsp_valid = 1'b0; settle();
    chk("fair_outstanding", outstanding, 0);

    // Full FIFO: four accepts, stall, one pop frees exactly one slot on the next cycle
    for (int c = 0; c < 12; c++) begin
      tick(); down_ready = 1'b1;
      req_valid = (c <= 6) ? 2'b01 : 2'b00;
      req_data  = {16'h0, 16'h00C0 + 16'((c < 4) ? c : 4)};
      if (c < 4 || c == 6) exp_down.push_back(16'h00C0 + 16'((c < 4) ? c : 4));
      rsp_valid = (c == 5) || (c >= 8);
      rsp_data  = (c == 5) ? 8'h60 : 8'h61 + 8'(c - 8);
      if (c == 5 || c >= 8) exp_rsp.push_back({2'b01, rsp_data});
      settle();
      if (c < 4)  chk("full_req_ready", req_ready, 2'b01);
      if (c == 4) chk("full_req_blocked", req_ready, 2'b00);
      if (c == 4) chk("full_outstanding", outstanding, 4);
      if (c == 5) chk("full_no_bypass", req_ready, 2'b00);
      if (c == 5) chk("full_rsp_route", out_rsp_valid, 2'b01);
      if (c == 6) chk("full_slot_freed", req_ready, 2'b01);
      if (c == 6) chk("full_outstanding_pop", outstanding, 3);
      if (c == 7) chk("full_outstanding_refill", outstanding, 4);
    end
    tick(); rsp_valid = 1'b0; settle();
    chk("full_outstanding_done", outstanding, 0);

    // Backpressure then stalled response owner
    for (int c = 0; c < 12; c++) begin
      tick();
      req_data      = 32'h00D1_00D0;
      req_valid     = (c <= 4) ? 2'b11 : 2'b00;
      down_ready    = !(c >= 1 && c <= 3);
      rsp_valid     = (c >= 6 && c <= 10);
      rsp_data      = (c <= 9) ? 8'h70 : 8'h71;
      out_rsp_ready = (c <= 7) ? 2'b00 : (c == 8) ? 2'b01 : (c == 9) ? 2'b10 : 2'b11;
      if (c == 0) exp_down.push_back(16'h00D1);
      if (c == 4) exp_down.push_back(16'h00D0);
      if (c == 9) exp_rsp.push_back({2'b10, 8'h70});
      if (c == 10) exp_rsp.push_back({2'b01, 8'h71});
      settle();
      if (c == 0) chk("bp_first_grant", req_ready, 2'b10);
      if (c >= 1 && c <= 3) chk("bp_req_ready", req_ready, 2'b00);
      if (c >= 1 && c <= 3) chk("bp_down_hold", down_data, 16'h00D1);
      if (c == 4) chk("bp_other_grant", req_ready, 2'b01);
      if (c >= 6 && c <= 8) chk("stall_rsp_ready", rsp_ready, 0);
      if (c >= 6 && c <= 8) chk("stall_rsp_valid", out_rsp_valid, 2'b10);
      if (c >= 6 && c <= 8) chk("stall_outstanding", outstanding, 2);
      if (c == 9) chk("stall_release", rsp_ready, 1);
      if (c == 11) chk("bp_outstanding_done", outstanding, 0);
    end

    // Orphan response: never acknowledged, sticky until reset
    tick(); rsp_valid = 1'b1; rsp_data = 8'h99; out_rsp_ready = 2'b11; settle();
    chk("orphan_rsp_ready", rsp_ready, 0);
    chk("orphan_route", out_rsp_valid, 2'b00);
    chk("orphan_before_edge", orphan_err, 0);
    tick(); rsp_valid = 1'b0; settle();
    chk("orphan_set", orphan_err, 1);
    tick(); settle();
    chk("orphan_sticky", orphan_err, 1);
    tick(); nreset = 1'b0; settle();
    chk("orphan_cleared", orphan_err, 0);
    tick(); nreset = 1'b1; rsp_valid = 1'b1; settle();
    tick(); rsp_valid = 1'b0; settle();
    chk("orphan_after_reset", orphan_err, 1);

    tick(); settle();
    chk("down_queue_empty", exp_down.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Shares one downstream request channel, the single memory port, between N_REQ upstream requesters such as instruction fetch and load/store, using round-robin arbitration. Every channel uses the team's ready/valid skid-port handshake. The block records the owner of each accepted request in an in-order ID FIFO, so returning responses go back to the requester that issued them. It sits between the pipeline's request skid buffers and the memory interface.

## Interface
- REQ_T, (none), request payload type
- RSP_T, (none), response payload type
- N_REQ, 2, number of requesters, 2..8
- DEPTH, 4, maximum outstanding requests (ID FIFO depth), power of two, ≥2
- clock  in  1  all state updates on the falling edge
- nreset  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester request accept, combinational
- req_data  in  N_REQ×$bits(REQ_T)  per-requester payload
- down_valid  out  1  registered request valid to memory
- down_ready  in  1  memory accepts request
- down_data  out  $bits(REQ_T)  registered request payload
- rsp_valid  in  1  memory response valid
- rsp_ready  out  1  response consumed, combinational
- rsp_data  in  $bits(RSP_T)  memory response payload
- out_rsp_valid  out  N_REQ  one-hot response valid to the owning requester
- out_rsp_ready  in  N_REQ  per-requester response ready
- out_rsp_data  out  $bits(RSP_T)  rsp_data broadcast to all requesters
- outstanding  out  $clog2(DEPTH+1)  ID FIFO occupancy
- orphan_err  out  1  sticky flag: a response arrived with no owner

## Operation
- A handshake on any channel completes at a falling edge where valid and ready are both high.
- load_en = (!down_valid || down_ready) && (outstanding < DEPTH). There is no bypass: a pop in the same cycle does not free a slot for that cycle's push.
- Round-robin pointer `last` (reset value N_REQ-1). The winner g is the first i with req_valid[i], searching from last+1 upward and wrapping modulo N_REQ.
- req_ready[i] = load_en && req_valid[i] && (i == g). At most one bit is set at a time.
- On an accept:
  - down_data <= req_data[g], down_valid <= 1
  - push g into the ID FIFO
  - last <= g
- With load_en high and no req_valid: down_valid <= 0 (the register drains); last is unchanged.
- With down_valid && !down_ready: down_valid and down_data hold.
- Response routing:
  - head = ID at the front of the FIFO.
  - out_rsp_valid[i] = rsp_valid && !empty && (head == i).
  - rsp_ready = !empty && out_rsp_ready[head].
  - out_rsp_data = rsp_data.
  - A pop happens on the rsp_valid && rsp_ready handshake.
- outstanding: +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- Pointer widths are $clog2(DEPTH). Read and write pointers wrap naturally.
- orphan_err is set at the edge where rsp_valid is high and the FIFO is empty. It clears only on reset. An orphaned response is never acknowledged (rsp_ready = 0).

## Timing
- Reset values (take effect immediately on nreset low, asynchronously):
  - down_valid 0, down_data 0
  - FIFO empty, outstanding 0, orphan_err 0
  - last = N_REQ-1, so requester 0 wins first
- During reset, req_ready, rsp_ready and out_rsp_valid evaluate from the reset state: req_ready = one-hot of the lowest valid requester; responses are not routed.
- Reset mid-operation drops all in-flight IDs. Responses that arrive after reset count as orphans.
- Request latency: an accept at edge k gives down_valid high from edge k to at least edge k+1.
- Throughput: one request per cycle while down_ready stays high and outstanding < DEPTH.
- Response path is combinational, zero cycles from rsp_valid to out_rsp_valid.
- A request and its response may handshake in consecutive cycles.
- Payload stability: down_data never changes while down_valid && !down_ready.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ accepts.

## Test plan
- Reset: drive nreset low mid-burst with outstanding=3 -> down_valid=0, outstanding=0, orphan_err=0 immediately. First grant after release goes to requester 0.
- Single requester: req_valid=01, data 0x100, down_ready=1 -> down_valid high after the next edge with down_data=0x100, outstanding=1. Then rsp_valid with data 0xAB -> out_rsp_valid=01, out_rsp_data=0xAB, outstanding=0.
- Fairness: N_REQ=2, both valid every cycle, down_ready=1, memory returns responses immediately -> grants alternate 0,1,0,1. Responses route 01,10,01,10.
- Full: DEPTH=4, down_ready=1, no responses -> after 4 accepts req_ready=00 and outstanding=4. One response pop -> exactly one new accept on the following edge.
- Backpressure: down_ready=0 for 3 cycles with both requesters valid -> down_data holds the first payload, req_ready=00. down_ready=1 -> next grant goes to the other requester.
- Orphan and stalled owner: rsp_valid with an empty FIFO -> orphan_err=1, rsp_ready=0. Head owner 1 with out_rsp_ready=00 -> rsp_ready=0 and the FIFO holds until out_rsp_ready[1]=1.
